refill_arbiter: RTL

//  Shares one 32-bit AXI4 burst-read port between icache and dcache line refills.

---
 rtl/refill_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/refill_arbiter.sv
// refill_arbiter
//   Shares one 32-bit AXI4 burst-read port between the icache and dcache line
//   refill interfaces. One pending requester is granted in IDLE. Its line
//   address is issued as a single INCR burst of LINE_WORDS beats, and the
//   beats are packed into a line. The line is then returned to the winner with
//   a one-cycle ret_valid pulse. Only one burst is ever outstanding.
//
//   Build option: define ARB_ROUND_ROBIN_EN to replace the fixed priority
//   (dcache wins ties) with round-robin tie-breaking, using a 1-bit
//   last_grant register that resets to icache.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   i_rd_req, i_rd_addr        icache refill request (level) and miss address
//   i_ret_valid, i_ret_data    icache line return pulse and packed line
//   d_rd_req, d_rd_addr        dcache refill request (level) and miss address
//   d_ret_valid, d_ret_data    dcache line return pulse and packed line
//   arvalid, arready, araddr,  AXI read-address channel (arlen/arsize/arburst
//   arid, arlen, arsize,       are constant: LINE_WORDS-1, 4-byte beats, INCR)
//   arburst
//   rvalid, rready, rdata,     AXI read-data channel
//   rlast
//   bus_err                    sticky flag: rlast disagreed with beat count
module refill_arbiter #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] ICACHE_ID  = 4'd0,
  parameter logic [3:0] DCACHE_ID  = 4'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_rd_req,
  input  logic [31:0]               i_rd_addr,
  output logic                      i_ret_valid,
  output logic [32*LINE_WORDS-1:0]  i_ret_data,
  input  logic                      d_rd_req,
  input  logic [31:0]               d_rd_addr,
  output logic                      d_ret_valid,
  output logic [32*LINE_WORDS-1:0]  d_ret_data,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [31:0]               araddr,
  output logic [3:0]                arid,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [31:0]               rdata,
  input  logic                      rlast,
  output logic                      bus_err
);

  localparam int          CW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int          OFF        = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [CW-1:0] LAST     = CW'(LINE_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    owner_d;
  logic [31:0]             addr;
  logic [32*LINE_WORDS-1:0] line;
  logic                    i_pend;
  logic                    d_pend;
  logic                    pick_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                    last_grant;  // 1 = dcache was granted last
`endif

  // The return pulse is registered, so it is seen during the IDLE cycle that
  // follows RET. The owner still holds its request in that cycle, so a
  // requester whose pulse is currently high is not eligible for a new grant.
  always_comb begin
    i_pend = i_rd_req && !i_ret_valid;
    d_pend = d_rd_req && !d_ret_valid;
    pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_pend && (!i_pend || !last_grant);
`else
    pick_d = d_pend;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_d     <= 1'b0;
      addr        <= '0;
      line        <= '0;
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
      i_ret_data  <= '0;
      d_ret_data  <= '0;
      bus_err     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_pend || d_pend) begin
            owner_d <= pick_d;
            addr    <= (pick_d ? d_rd_addr : i_rd_addr) & ALIGN_MASK;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick_d;
`endif
            state   <= AR;
          end
        end
        AR: begin
          if (arready) state <= R;
        end
        R: begin
          if (rvalid) begin
            line[32*cnt +: 32] <= rdata;
            if (rlast != (cnt == LAST)) bus_err <= 1'b1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= RET;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (owner_d) begin
            d_ret_valid <= 1'b1;
            d_ret_data  <= line;
          end else begin
            i_ret_valid <= 1'b1;
            i_ret_data  <= line;
          end
          state <= IDLE;
        end
      endcase
    end
  end

  assign arvalid = (state == AR);
  assign rready  = (state == R);
  assign araddr  = addr;
  assign arid    = owner_d ? DCACHE_ID : ICACHE_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

endmodule
